cla8_sequencer: RTL

Sequential front/back end for the gate-level 8-bit carry-lookahead adder built from delay-annotated primitives. Accepts operands over a valid/ready handshake and drives them onto the combinational adder. Waits a fixed number of clocks for gate propagation to settle, then samples sum/carry and derives status flags. Checks the sampled result against a behavioural sum and counts mismatches, so gate-delay violations are visible in simulation.

---
 rtl/cla8_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cla8_sequencer.sv
// cla8_sequencer: sequential wrapper around an external combinational 8-bit
// carry-lookahead adder. It registers the operands onto the adder and waits a
// fixed number of clocks for the gates to settle. It then samples sum/carry,
// derives the status flags and flags any disagreement with a behavioural sum.
module cla8_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_cin,
  output logic [7:0]       cla_a,
  output logic [7:0]       cla_b,
  output logic             cla_cin,
  input  logic [7:0]       cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_mismatch,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);

  // Counter just wide enough to hold SETTLE_CYCLES-1 (at least one bit).
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("cla8_sequencer: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t     state;
  logic [CW-1:0] settle_cnt;
  logic [8:0] expected;

  // Values derived from the adder outputs, consumed at the sampling edge.
  logic       sample_now;
  logic       ovf_now;
  logic       zero_now;
  logic       mism_now;
  logic [8:0] expected_next;

  // Accept only in IDLE, and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // Combinational status derivation from the live adder outputs.
  always_comb begin
    sample_now    = 1'b0;
    ovf_now       = 1'b0;
    zero_now      = 1'b0;
    mism_now      = 1'b0;
    expected_next = '0;
    sample_now    = (state == SETTLE) && (settle_cnt == '0);
    ovf_now       = (cla_a[7] == cla_b[7]) && (cla_sum[7] != cla_a[7]);
    zero_now      = (cla_sum == 8'h00);
    mism_now      = ({cla_cout, cla_sum} != expected);
    expected_next = {1'b0, in_a} + {1'b0, in_b} + {8'h00, in_cin};
  end

  // Control FSM with registered adder drive and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      expected     <= '0;
      cla_a        <= '0;
      cla_b        <= '0;
      cla_cin      <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_cout     <= 1'b0;
      out_ovf      <= 1'b0;
      out_zero     <= 1'b0;
      out_mismatch <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cla_a      <= in_a;
            cla_b      <= in_b;
            cla_cin    <= in_cin;
            expected   <= expected_next;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (sample_now) begin
            out_sum      <= cla_sum;
            out_cout     <= cla_cout;
            out_zero     <= zero_now;
            out_ovf      <= ovf_now;
            out_mismatch <= mism_now;
            out_valid    <= 1'b1;
            state        <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating mismatch counter; a clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (sample_now && mism_now && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
